// File: rtl/uart_rx_framer_pkg.sv
// Shared types and constants for the UART receive framer and its staging FIFO.
package uart_rx_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAY,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } entry_t;

endpackage

// File: rtl/framer_fifo.sv
// Sync FIFO with a speculative write pointer: pushes stay invisible to the reader
// until commit; rollback discards everything written since the last commit.
module framer_fifo
  import uart_rx_framer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       pop,
  input  logic       commit,
  input  logic       rollback,
  output logic       has_room,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_last
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] cptr;
  logic [AW:0] rptr;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_valid = (rptr != cptr);
  assign do_pop   = pop && rd_valid;
  // A pop in this cycle frees its slot for a push in the same cycle.
  assign has_room = !full || do_pop;
  assign do_push  = push && has_room;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      cptr <= '0;
      rptr <= '0;
    end else begin
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (rollback)
        wptr <= cptr;
      else if (do_push)
        wptr <= wptr + 1'b1;
      if (commit)
        cptr <= wptr;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= '{data: wr_data, last: wr_last};
  end

  // Gate with valid so the outputs read zero while nothing is committed.
  assign head    = mem[rptr[AW-1:0]];
  assign rd_data = rd_valid ? head.data : 8'h00;
  assign rd_last = rd_valid ? head.last : 1'b0;

endmodule

// File: rtl/uart_rx_framer.sv
// Frame parser behind uart_rx: SOF, LEN, payload, CSUM. Payload is staged in a
// commit/rollback FIFO and only checksum-verified frames reach the consumer.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter int         MAX_LEN  = 12,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int         TIMEOUT  = 4096
) (
  input  logic        clock,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy,
  output logic [15:0] o_frames,
  output logic [15:0] o_errors
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    sum;
  logic [7:0]    remaining;
  logic          mark_ok;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          strobe;
  logic          push;
  logic          commit;
  logic          rollback;
  logic          good;
  logic          bad;
  logic          has_room;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A strobe coinciding with the timeout is swallowed by the abort.
  assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign strobe  = i_rx_valid && !tmo_hit;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    if (tmo_hit) begin
      rollback  = 1'b1;
      bad       = 1'b1;
      state_nxt = ST_IDLE;
    end else if (i_rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (i_rx_data == SOF_BYTE)
            state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if (i_rx_data > 8'(MAX_LEN)) begin
            bad       = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = (i_rx_data == 8'd0) ? ST_CSUM : ST_PAY;
          end
        end
        ST_PAY: begin
          push = has_room;
          if (remaining == 8'd1)
            state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          if ((i_rx_data == sum) && mark_ok) begin
            commit = 1'b1;
            good   = 1'b1;
          end else begin
            rollback = 1'b1;
            bad      = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control state: FSM, frame bookkeeping, idle timer, statistics
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      remaining <= 8'd0;
      mark_ok   <= 1'b0;
      tmo_cnt   <= '0;
      o_frames  <= 16'd0;
      o_errors  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_IDLE || i_rx_valid)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
      if (strobe && state == ST_LEN) begin
        remaining <= i_rx_data;
        mark_ok   <= 1'b1;
      end else if (strobe && state == ST_PAY) begin
        remaining <= remaining - 8'd1;
        if (!has_room)
          mark_ok <= 1'b0;
      end
      if (good)
        o_frames <= sat_inc(o_frames);
      if (bad)
        o_errors <= sat_inc(o_errors);
    end
  end

  // Datapath: running checksum, seeded by LEN
  always_ff @(posedge clock) begin
    if (strobe && state == ST_LEN)
      sum <= i_rx_data;
    else if (strobe && state == ST_PAY)
      sum <= sum + i_rx_data;
  end

  assign o_busy = (state != ST_IDLE);

  framer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .rst      (i_rst),
    .push     (push),
    .wr_data  (i_rx_data),
    .wr_last  (remaining == 8'd1),
    .pop      (i_ready),
    .commit   (commit),
    .rollback (rollback),
    .has_room (has_room),
    .rd_valid (o_valid),
    .rd_data  (o_data),
    .rd_last  (o_last)
  );

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: directed frame scenarios plus randomized frames.
module tb_uart_rx_framer;

  localparam int MAX_LEN = 12;
  localparam int TIMEOUT = 4096;

  logic        clock = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [7:0]  o_data;
  logic        o_last;
  logic        o_valid;
  logic        o_busy;
  logic [15:0] o_frames;
  logic [15:0] o_errors;

  int vectors = 0;
  int miscompares = 0;
  int exp_frames = 0;
  int exp_errors = 0;
  bit rand_ready = 1'b0;

  logic [8:0] expq [$];
  logic [7:0] pay [$];

  uart_rx_framer dut (
    .clock      (clock),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_frames   (o_frames),
    .o_errors   (o_errors)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: a transfer completes at the next rising edge when valid & ready.
  always @(negedge clock) begin
    if (!i_rst && o_valid && i_ready) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got data 0x%02h last %0b, expected nothing at %0t", o_data, o_last, $time);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        chk("out_data", o_data, e[8:1]);
        chk("out_last", o_last, e[0]);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_ready)
      i_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
    tick(gap);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] len);
    logic [7:0] s;
    s = len;
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  // Reference: a frame is good when LEN is legal and CSUM equals the mod-256 sum
  // of LEN and payload; good frames release their payload, last flag on the final byte.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] cs, input bit overflow, input int gap);
    bit ok;
    ok = (int'(len) <= MAX_LEN) && (cs == sum8(len)) && !overflow;
    if (ok) begin
      foreach (pay[i]) expq.push_back({pay[i], (i == pay.size() - 1)});
      exp_frames++;
    end else begin
      exp_errors++;
    end
    send_byte(8'hA5, (gap < 0) ? $urandom_range(0, 3) : gap);
    send_byte(len, (gap < 0) ? $urandom_range(0, 3) : gap);
    if (int'(len) <= MAX_LEN) begin
      foreach (pay[i]) send_byte(pay[i], (gap < 0) ? $urandom_range(0, 3) : gap);
      send_byte(cs, (gap < 0) ? $urandom_range(0, 3) : gap);
    end
  endtask

  task automatic rand_pay(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    chk({name, "_drain_left"}, expq.size(), 0);
    tick(3);
    chk({name, "_valid_idle"}, o_valid, 0);
    chk({name, "_frames"}, o_frames, exp_frames);
    chk({name, "_errors"}, o_errors, exp_errors);
    chk({name, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frames", o_frames, 0);
    chk("rst_errors", o_errors, 0);
    @(posedge clock);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    tick(2);

    // Good frame
    pay = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, 8'h69, 1'b0, 0);
    drain("good");

    // Bad checksum: nothing may become visible
    pay = '{8'h10, 8'h20};
    send_frame(8'd2, 8'h00, 1'b0, 0);
    tick(3);
    chk("badcs_valid", o_valid, 0);
    pay = '{8'h7F};
    send_frame(8'd1, 8'h80, 1'b0, 0);
    drain("badcs");

    // Overflow under backpressure: second frame cannot fit and is rolled back
    i_ready = 1'b0;
    rand_pay(12);
    send_frame(8'd12, sum8(8'd12), 1'b0, 0);
    rand_pay(12);
    send_frame(8'd12, sum8(8'd12), 1'b1, 0);
    tick(3);
    chk("ovf_errors", o_errors, exp_errors);
    chk("ovf_valid", o_valid, 1);
    i_ready = 1'b1;
    drain("ovf");

    // Timeout mid-payload, then a long-but-legal gap, then recovery
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    tick(TIMEOUT + 4);
    exp_errors++;
    chk("tmo_busy", o_busy, 0);
    chk("tmo_valid", o_valid, 0);
    chk("tmo_errors", o_errors, exp_errors);
    pay = '{8'h01, 8'h02};
    send_frame(8'd2, 8'h05, 1'b0, TIMEOUT - 200);
    drain("tmo");

    // Edge frames: empty payload, oversize LEN, stray byte in IDLE
    pay.delete();
    send_frame(8'd0, 8'h00, 1'b0, 0);
    send_frame(8'd13, 8'h00, 1'b0, 0);
    chk("oversize_busy", o_busy, 0);
    send_byte(8'h55, 2);
    drain("edge");

    // Asynchronous reset mid-payload with committed data pending
    i_ready = 1'b0;
    pay = '{8'h21, 8'h43};
    send_frame(8'd2, sum8(8'd2), 1'b0, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h01, 0);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_frames", o_frames, 0);
    chk("arst_errors", o_errors, 0);
    expq.delete();
    exp_frames = 0;
    exp_errors = 0;
    tick(2);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    tick(1);
    pay = '{8'hA5, 8'h00, 8'hFF};
    send_frame(8'd3, sum8(8'd3), 1'b0, 0);
    drain("arst");

    // Randomized frames with random consumer backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, MAX_LEN);
      if (kind == 9) send_byte(8'($urandom_range(0, 164)), $urandom_range(0, 2));
      rand_pay(len);
      if (kind == 7)
        send_frame(8'(len), sum8(8'(len)) + 8'($urandom_range(1, 255)), 1'b0, -1);
      else if (kind == 8)
        send_frame(8'($urandom_range(MAX_LEN + 1, 255)), 8'h00, 1'b0, -1);
      else
        send_frame(8'(len), sum8(8'(len)), 1'b0, -1);
      drain("rand");
    end
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
